// File: rtl/data_memory_controller.sv
// rtl/data_memory_controller.sv - MEM-stage load/store initiator with sub-word RMW and load extension
module data_memory_controller #(
    parameter int NB_ADDR = 7,
    parameter int NB_DATA = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    input  logic [31:0]        i_addr,
    input  logic [NB_DATA-1:0] i_wdata,
    output logic               o_stall,
    output logic [NB_DATA-1:0] o_rdata,
    output logic               o_rdata_valid,
    output logic               o_misaligned,
    output logic               o_mem_write_data,
    output logic               o_mem_read_data,
    output logic [NB_ADDR-1:0] o_write_addr,
    output logic [NB_ADDR-1:0] o_read_addr,
    output logic [NB_DATA-1:0] o_write_data,
    input  logic [NB_DATA-1:0] i_mem_data
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         lane_q, lane_d;
    logic [1:0]         size_q, size_d;
    logic               unsigned_q, unsigned_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [NB_DATA-1:0] rdata_q, rdata_d;

    logic [NB_ADDR-1:0] word_addr;
    logic               is_req;
    logic               is_byte;
    logic               is_half;
    logic               misalign;
    logic               unused_addr_hi;

    // Address bits above the memory depth wrap and are deliberately dropped.
    assign word_addr      = i_addr[NB_ADDR+1:2];
    assign unused_addr_hi = ^i_addr[31:NB_ADDR+2];
    assign is_req         = i_valid & (i_mem_read | i_mem_write);
    assign is_byte        = (i_size == 2'b00);
    assign is_half        = (i_size == 2'b01);
    // Size 11 falls through as a word access.
    assign misalign       = is_half ? i_addr[0] : (!is_byte && (i_addr[1:0] != 2'b00));

    // Pick the addressed lane(s) out of a memory word and sign/zero extend.
    function automatic logic [NB_DATA-1:0] extract_lane(
        input logic [NB_DATA-1:0] word,
        input logic [1:0]         lane,
        input logic [1:0]         size,
        input logic               zext
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   extract_lane = {{24{~zext & b[7]}}, b};
            2'b01:   extract_lane = {{16{~zext & h[15]}}, h};
            default: extract_lane = word;
        endcase
    endfunction

    // Overlay the store lane(s) onto the word read back from memory.
    function automatic logic [NB_DATA-1:0] merge_lane(
        input logic [NB_DATA-1:0] word,
        input logic [1:0]         lane,
        input logic [1:0]         size,
        input logic [15:0]        data
    );
        logic [NB_DATA-1:0] m;
        m = word;
        if (size == 2'b00) begin
            m[{lane, 3'b000} +: 8] = data[7:0];
        end else if (lane[1]) begin
            m[31:16] = data;
        end else begin
            m[15:0] = data;
        end
        merge_lane = m;
    endfunction

    // Next-state and memory-side outputs; everything forced quiet while reset is held.
    always_comb begin
        state_d          = state_q;
        lane_d           = lane_q;
        size_d           = size_q;
        unsigned_d       = unsigned_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        o_stall          = 1'b0;
        o_rdata          = rdata_q;
        o_rdata_valid    = 1'b0;
        o_misaligned     = 1'b0;
        o_mem_write_data = 1'b0;
        o_mem_read_data  = 1'b0;
        o_write_addr     = '0;
        o_read_addr      = '0;
        o_write_data     = '0;

        case (state_q)
            IDLE: begin
                if (is_req) begin
                    if (misalign) begin
                        o_misaligned = 1'b1;
                    end else if (i_mem_read) begin
                        o_mem_read_data = 1'b1;
                        o_read_addr     = word_addr;
                        o_stall         = 1'b1;
                        lane_d          = i_addr[1:0];
                        size_d          = i_size;
                        unsigned_d      = i_unsigned;
                        state_d         = LOAD_WAIT;
                    end else if (!is_byte && !is_half) begin
                        o_mem_write_data = 1'b1;
                        o_write_addr     = word_addr;
                        o_write_data     = i_wdata;
                    end else begin
                        o_mem_read_data = 1'b1;
                        o_read_addr     = word_addr;
                        o_stall         = 1'b1;
                        lane_d          = i_addr[1:0];
                        size_d          = i_size;
                        addr_d          = word_addr;
                        wdata_d         = i_wdata[15:0];
                        state_d         = RMW_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                rdata_d       = extract_lane(i_mem_data, lane_q, size_q, unsigned_q);
                o_rdata       = rdata_d;
                o_rdata_valid = 1'b1;
                state_d       = IDLE;
            end
            RMW_WAIT: begin
                o_mem_write_data = 1'b1;
                o_write_addr     = addr_q;
                o_write_data     = merge_lane(i_mem_data, lane_q, size_q, wdata_q);
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (i_reset) begin
            o_stall          = 1'b0;
            o_rdata          = '0;
            o_rdata_valid    = 1'b0;
            o_misaligned     = 1'b0;
            o_mem_write_data = 1'b0;
            o_mem_read_data  = 1'b0;
            o_write_addr     = '0;
            o_read_addr      = '0;
            o_write_data     = '0;
        end
    end

    // State and request latches; reset abandons any in-flight access.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule
